temporizador_semaforo: RTL
==========================

Name: temporizador_semaforo

Overview:
- Companion block that drives the traffic-light controller's CAR and TIMEOUT inputs from its VERDE/AMARELO/VERMELHO outputs.
- Synchronises and debounces a raw car sensor. Holds a car request until the light acknowledges it by turning AMARELO, and not before a minimum green time.
- Times the red phase and asserts TIMEOUT until the light leaves VERMELHO.
- Flags illegal (non-one-hot) light combinations.

Parameters:
DEB, 3, consecutive cycles the synchronised sensor must disagree with the debounced value before that value toggles (>=1)
T_VERDE_MIN, 4, minimum cycles VERDE must be sampled high before CAR may assert (>=1)
T_VERMELHO, 6, cycles VERMELHO must be sampled high before TIMEOUT asserts (>=1)
CNT_W, 8, width of phase and debounce counters; every T_* and DEB must be < 2^CNT_W

Ports:
clk  in  1  system clock, rising edge
res  in  1  asynchronous, active-high reset
SENSOR  in  1  raw car sensor, asynchronous to clk
VERDE  in  1  green light from controller, synchronous to clk
AMARELO  in  1  yellow light from controller, synchronous to clk
VERMELHO  in  1  red light from controller, synchronous to clk
CAR  out  1  registered car request to controller
TIMEOUT  out  1  registered red-phase timeout to controller
ERRO  out  1  registered illegal-light flag

Behaviour:
- Reset (res=1, asynchronous): all state and outputs clear to 0.
  - CAR=0, TIMEOUT=0, ERRO=0.
  - Sync FFs, sens_db, sens_db_d, deb_cnt, phase counter cnt, prev light vector and pend all clear to 0.
- Sensor path: 2-FF synchroniser s1→s2.
  - deb_cnt increments on each edge where s2 != sens_db; it clears on any edge where they agree.
  - On the edge where deb_cnt would reach DEB, sens_db toggles and deb_cnt clears.
  - Glitches shorter than DEB cycles have no effect.
- Debounced rise: rise = sens_db & ~sens_db_d, with sens_db_d a one-cycle delay of sens_db.
- Light decode: L = {VERDE, AMARELO, VERMELHO}. Legal only if exactly one bit is set.
- Phase counter, per edge:
  - If L is illegal: cnt<=0.
  - Else if L != prev: cnt<=1 (phase entry).
  - Else: cnt<=cnt+1, saturating at 2^CNT_W-1.
  - prev<=L every edge; prev is cleared to 0 while L is illegal.
- Pending request pend, per edge (priority top-down):
  - L illegal: 0.
  - AMARELO=1: 0 (acknowledge).
  - rise=1: 1.
  - VERDE phase entry with sens_db=1: 1, so a car still present when green returns is served.
  - Otherwise hold.
  - A rise during VERMELHO sets pend. It is served in the next green.
- Outputs: registered. Primes denote the values loaded at the same edge.
  - CAR <= pend' & VERDE & (cnt' >= T_VERDE_MIN)
  - TIMEOUT <= VERMELHO & (cnt' >= T_VERMELHO)
  - ERRO <= L illegal
- Consequences:
  - CAR falls on the first edge sampling AMARELO=1.
  - TIMEOUT rises on the T_VERMELHO-th consecutive edge sampling VERMELHO=1. It stays high while VERMELHO stays high and falls on the first edge sampling VERMELHO=0.
  - CAR and TIMEOUT are never high together.
- Latency: take SENSOR stable high from before edge 0, with green already mature.
  - sens_db rises at edge DEB+1.
  - pend and CAR rise at edge DEB+2 (edge 5 with defaults).
- Illegal lights (000, or 2+ bits set): CAR, TIMEOUT and pend clear on that edge and ERRO=1. On return to a legal L, the legal phase is a fresh entry (cnt=1) and ERRO clears on that edge.
- Saturation: counters never wrap. A permanently red light keeps TIMEOUT high indefinitely.
- Reset mid-operation clears CAR/TIMEOUT immediately (asynchronously). After release, the current light counts as a fresh entry.

Test Plan:
1. Reset, VERDE=1 held 10 cycles, SENSOR=0 → CAR, TIMEOUT, ERRO stay 0; cnt saturation is not reached.
2. VERDE held, SENSOR raised at edge 0 and held (defaults) → CAR=1 at edge 5. Drive AMARELO=1, VERDE=0 → CAR=0 on the first edge sampling AMARELO.
3. SENSOR raised at VERDE entry edge 0 → CAR is blocked until cnt'=4; CAR=1 at edge 5 (debounce-limited). With DEB=1, CAR=1 at edge 3 (T_VERDE_MIN-limited).
4. SENSOR pulses of 1 and 2 cycles, then 3 cycles → no sens_db change for the short pulses; the 3-cycle pulse toggles sens_db. CAR follows only if VERDE is mature.
5. VERMELHO=1 from edge 0 → TIMEOUT=1 at edge 5 (6th sample) and held. Drive VERDE=1 → TIMEOUT=0 on that edge. A SENSOR rise during red gives CAR=1 after 4 green edges.
6. Drive VERDE=AMARELO=1 mid-request → ERRO=1, CAR=0 that edge. Then VERDE only → ERRO=0, cnt restarts at 1. Assert res mid-TIMEOUT → TIMEOUT=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/temporizador_semaforo.sv
// Companion timer for the traffic-light controller: debounced car request (CAR),
// red-phase timeout (TIMEOUT) and illegal-light flag (ERRO), all registered.
module temporizador_semaforo #(
  parameter int DEB         = 3,
  parameter int T_VERDE_MIN = 4,
  parameter int T_VERMELHO  = 6,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic res,
  input  logic SENSOR,
  input  logic VERDE,
  input  logic AMARELO,
  input  logic VERMELHO,
  output logic CAR,
  output logic TIMEOUT,
  output logic ERRO
);

  localparam logic [CNT_W-1:0] DEB_C     = CNT_W'(DEB);
  localparam logic [CNT_W-1:0] T_VMIN_C  = CNT_W'(T_VERDE_MIN);
  localparam logic [CNT_W-1:0] T_VERM_C  = CNT_W'(T_VERMELHO);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             s1, s2;
  logic             sens_db, sens_db_d;
  logic [CNT_W-1:0] deb_cnt, deb_inc;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       light, prev;
  logic             legal, entry, rise;
  logic             pend, pend_nxt;

  always_comb begin
    light   = {VERDE, AMARELO, VERMELHO};
    legal   = (light == 3'b100) || (light == 3'b010) || (light == 3'b001);
    entry   = legal && (light != prev);
    rise    = sens_db & ~sens_db_d;
    deb_inc = deb_cnt + 1'b1;

    cnt_nxt = cnt;
    if (!legal)
      cnt_nxt = '0;
    else if (entry)
      cnt_nxt = CNT_W'(1);
    else if (cnt != CNT_MAX)
      cnt_nxt = cnt + 1'b1;

    // Acknowledge (AMARELO) outranks a new rise; a car still waiting when
    // green comes back is re-armed on the green entry edge.
    pend_nxt = pend;
    if (!legal)
      pend_nxt = 1'b0;
    else if (AMARELO)
      pend_nxt = 1'b0;
    else if (rise)
      pend_nxt = 1'b1;
    else if (VERDE && entry && sens_db)
      pend_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      sens_db   <= 1'b0;
      sens_db_d <= 1'b0;
      deb_cnt   <= '0;
      cnt       <= '0;
      prev      <= 3'b000;
      pend      <= 1'b0;
      CAR       <= 1'b0;
      TIMEOUT   <= 1'b0;
      ERRO      <= 1'b0;
    end else begin
      s1 <= SENSOR;
      s2 <= s1;

      if (s2 != sens_db) begin
        if (deb_inc == DEB_C) begin
          sens_db <= ~sens_db;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_inc;
        end
      end else begin
        deb_cnt <= '0;
      end
      sens_db_d <= sens_db;

      cnt     <= cnt_nxt;
      prev    <= legal ? light : 3'b000;
      pend    <= pend_nxt;
      CAR     <= pend_nxt & VERDE & (cnt_nxt >= T_VMIN_C);
      TIMEOUT <= VERMELHO & (cnt_nxt >= T_VERM_C);
      ERRO    <= ~legal;
    end
  end

endmodule
